// File: rtl/mem_rw_pkg.sv
// Shared types and constants for the memory read/write arbiter.
// Holds the FSM state encoding, the dual-rail RW token codes and requester IDs,
// plus a helper that sizes the handshake timeout counter.
package mem_rw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT_ACK,
    ST_NULL,
    ST_WAIT_RLS,
    ST_FAULT
  } state_e;

  // Dual-rail token, packed as {rw_t, rw_f}.
  localparam logic [1:0] RW_NULL  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  // Requester identities; also the encoding of the round-robin priority pointer.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LS    = 1'b1;

  // Counter must hold TIMEOUT and is never narrower than 8 bits.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Latency: STAGES cycles from d_i to q_o. No backpressure.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized output).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store that issues one
// dual-rail RW token per grant to an asynchronous stage and completes a 4-phase
// handshake on ack_in. Latency: grant and token one cycle after req; NULL and done
// each SYNC_STAGES+1 cycles after the corresponding ack_in edge. Backpressure: the
// winner holds gnt until done; requests are not sampled again until the FSM is idle.
// Ports: clk, rst_n; fetch_req, ls_req, ls_we (requesters); fetch_gnt, ls_gnt, done
// (grant / completion); rw_t, rw_f, ack_in (dual-rail handshake); err (sticky timeout).
module mem_rw_arbiter
  import mem_rw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  input  logic ls_req,
  input  logic ls_we,
  output logic fetch_gnt,
  output logic ls_gnt,
  output logic done,
  output logic rw_t,
  output logic rw_f,
  input  logic ack_in,
  output logic err
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       rw_q, rw_d;
  logic             gnt_f_q, gnt_f_d;
  logic             gnt_l_q, gnt_l_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             prio_q, prio_d;  // requester that wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ack_s;
  logic winner;
  logic timeout_hit;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  assign winner = (fetch_req && ls_req) ? prio_q : (ls_req ? REQ_LS : REQ_FETCH);

  // Fire on the cycle the count would reach TIMEOUT, so exactly TIMEOUT cycles
  // are spent waiting before the fault is taken.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    gnt_f_d = gnt_f_q;
    gnt_l_d = gnt_l_q;
    done_d  = 1'b0;
    err_d   = err_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req || ls_req) begin
          state_d = ST_DATA;
          gnt_f_d = (winner == REQ_FETCH);
          gnt_l_d = (winner == REQ_LS);
          // Direction is captured here; later ls_we changes cannot reach the token.
          rw_d    = ((winner == REQ_LS) && ls_we) ? RW_WRITE : RW_READ;
          prio_d  = (winner == REQ_LS) ? REQ_FETCH : REQ_LS;
        end
      end

      ST_DATA: begin
        state_d = ST_WAIT_ACK;
        cnt_d   = '0;
      end

      ST_WAIT_ACK: begin
        if (ack_s) begin
          state_d = ST_NULL;
          rw_d    = RW_NULL;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          rw_d    = RW_NULL;
          gnt_f_d = 1'b0;
          gnt_l_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_NULL: begin
        state_d = ST_WAIT_RLS;
        cnt_d   = '0;
      end

      ST_WAIT_RLS: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          gnt_f_d = 1'b0;
          gnt_l_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          rw_d    = RW_NULL;
          gnt_f_d = 1'b0;
          gnt_l_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FAULT: begin
        rw_d    = RW_NULL;
        gnt_f_d = 1'b0;
        gnt_l_d = 1'b0;
      end

      default: begin
        // Unreachable encodings are treated as a handshake fault.
        state_d = ST_FAULT;
        err_d   = 1'b1;
        rw_d    = RW_NULL;
        gnt_f_d = 1'b0;
        gnt_l_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rw_q    <= RW_NULL;
      gnt_f_q <= 1'b0;
      gnt_l_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      prio_q  <= REQ_LS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      gnt_f_q <= gnt_f_d;
      gnt_l_q <= gnt_l_d;
      done_q  <= done_d;
      err_q   <= err_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {rw_t, rw_f} = rw_q;
  assign fetch_gnt    = gnt_f_q;
  assign ls_gnt       = gnt_l_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter: directed latency/arbitration/reset/timeout
// scenarios plus a randomized run scored against a transaction-level model.
module tb_mem_rw_arbiter;

  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_req = 1'b0;
  logic ls_req = 1'b0;
  logic ls_we = 1'b0;
  logic ack_in = 1'b0;
  logic fetch_gnt, ls_gnt, done, rw_t, rw_f, err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_rw_arbiter #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .fetch_gnt (fetch_gnt),
    .ls_gnt    (ls_gnt),
    .done      (done),
    .rw_t      (rw_t),
    .rw_f      (rw_f),
    .ack_in    (ack_in),
    .err       (err)
  );

  always @(negedge clk) begin
    if (rst_n) assert (!(rw_t && rw_f)) else $error("rw_t and rw_f both high");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ack_in = 1'b0;
    #1;
    chk("rst_gnt",  32'({fetch_gnt, ls_gnt}), 0);
    chk("rst_rw",   32'({rw_t, rw_f}), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Acts as the async stage: latch, wait for NULL, release, wait for done.
  task automatic handshake(input string tag);
    int n;
    ack_in = 1'b1;
    n = 0;
    while ((rw_t || rw_f) && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_null"}, 32'(n < 20), 1);
    ack_in = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_gnt_off"}, 32'({fetch_gnt, ls_gnt}), 0);
  endtask

  // Random-run model state
  int         owner;      // 0 none, 1 fetch, 2 ls
  logic       last_f;     // last winner was fetch, so ls wins a tie
  logic       pf, pl, pw; // inputs in effect at the last rising edge
  logic       win_ls;
  logic [1:0] exp_tok;
  logic       tok_gone, ack_seen;
  int         phase, dly, txns;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- fetch-only latency ----
    do_reset();
    fetch_req = 1'b1;
    @(negedge clk);
    chk("a_gnt", 32'({fetch_gnt, ls_gnt}), 32'h2);
    chk("a_tok", 32'({rw_t, rw_f}), 32'h1);
    fetch_req = 1'b0;                        // dropping req mid-transaction is ignored
    @(negedge clk);
    chk("a_hold", 32'({rw_t, rw_f}), 32'h1);
    ack_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_no_early_null", 32'({rw_t, rw_f}), 32'h1);
    @(negedge clk);
    chk("a_null", 32'({rw_t, rw_f}), 0);
    chk("a_gnt_in_null", 32'(fetch_gnt), 1);
    ack_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_no_early_done", 32'(done), 0);
    chk("a_gnt_before_done", 32'(fetch_gnt), 1);
    @(negedge clk);
    chk("a_done", 32'(done), 1);
    chk("a_gnt_drop", 32'(fetch_gnt), 0);
    @(negedge clk);
    chk("a_done_pulse", 32'(done), 0);
    chk("a_idle", 32'({fetch_gnt, ls_gnt, rw_t, rw_f}), 0);

    // ---- arbitration from reset, ls_we change after grant ----
    do_reset();
    fetch_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
    @(negedge clk);
    chk("b_first_ls", 32'({fetch_gnt, ls_gnt}), 32'h1);
    chk("b_write", 32'({rw_t, rw_f}), 32'h2);
    @(negedge clk);
    ls_we = 1'b0;
    @(negedge clk);
    chk("b_we_toggle", 32'({rw_t, rw_f}), 32'h2);
    handshake("b0");
    for (int i = 0; i < 3; i++) begin
      logic exp_ls;
      logic we_v;
      exp_ls = (i % 2 == 1);
      we_v   = 1'($urandom_range(0, 1));
      ls_we  = we_v;
      @(negedge clk);
      chk("b_alt_gnt", 32'({fetch_gnt, ls_gnt}), exp_ls ? 32'h1 : 32'h2);
      chk("b_alt_tok", 32'({rw_t, rw_f}), (exp_ls && we_v) ? 32'h2 : 32'h1);
      handshake("b_alt");
    end

    // ---- reset mid-WAIT_ACK restores ls priority ----
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1;
    @(negedge clk);
    chk("c_gnt", 32'(ls_gnt), 1);
    handshake("c0");
    @(negedge clk);
    chk("c_b2b", 32'({fetch_gnt, ls_gnt}), 32'h1);
    @(negedge clk);
    ack_in = 1'b1;
    @(negedge clk);
    chk("c_pre_rst", 32'({rw_t, rw_f}), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_rw", 32'({rw_t, rw_f}), 0);
    chk("c_rst_gnt", 32'({fetch_gnt, ls_gnt}), 0);
    chk("c_rst_done", 32'(done), 0);
    do_reset();
    fetch_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    @(negedge clk);
    chk("c_ptr_ls", 32'({fetch_gnt, ls_gnt}), 32'h1);
    chk("c_ptr_tok", 32'({rw_t, rw_f}), 32'h1);
    handshake("c1");

    // ---- randomized run against a transaction model ----
    do_reset();
    owner = 0; last_f = 1'b1; pf = 1'b0; pl = 1'b0; pw = 1'b0;
    tok_gone = 1'b0; ack_seen = 1'b0; phase = 0; dly = 0; txns = 0; exp_tok = 2'b00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk("r_excl", 32'(rw_t & rw_f), 0);
      chk("r_gnt_1hot", 32'(fetch_gnt & ls_gnt), 0);
      chk("r_err", 32'(err), 0);
      if (owner == 0) begin
        chk("r_done_idle", 32'(done), 0);
        if (pf || pl) begin
          win_ls  = (pf && pl) ? last_f : pl;
          chk("r_gnt", 32'({fetch_gnt, ls_gnt}), win_ls ? 32'h1 : 32'h2);
          exp_tok = (win_ls && pw) ? 2'b10 : 2'b01;
          chk("r_tok", 32'({rw_t, rw_f}), 32'(exp_tok));
          owner    = win_ls ? 2 : 1;
          last_f   = !win_ls;
          tok_gone = 1'b0;
          ack_seen = 1'b0;
          txns++;
        end else begin
          chk("r_idle", 32'({fetch_gnt, ls_gnt, rw_t, rw_f}), 0);
        end
      end else if ((owner == 1 && fetch_gnt) || (owner == 2 && ls_gnt)) begin
        chk("r_keep", 32'({fetch_gnt, ls_gnt}), (owner == 1) ? 32'h2 : 32'h1);
        chk("r_done_mid", 32'(done), 0);
        if (rw_t || rw_f) begin
          chk("r_tok_hold", 32'({rw_t, rw_f}), 32'(exp_tok));
          chk("r_no_retok", 32'(tok_gone), 0);
        end else begin
          if (!tok_gone) chk("r_null_after_ack", 32'(ack_seen), 1);
          tok_gone = 1'b1;
        end
      end else begin
        chk("r_done", 32'(done), 1);
        chk("r_end_rw", 32'({rw_t, rw_f}), 0);
        chk("r_end_gnt", 32'({fetch_gnt, ls_gnt}), 0);
        chk("r_end_ack", 32'(ack_in), 0);
        chk("r_end_null", 32'(tok_gone), 1);
        owner = 0;
      end

      case (phase)
        0: if (rw_t || rw_f) begin
             if (dly == 0) begin ack_in = 1'b1; ack_seen = 1'b1; phase = 1; end
             else dly--;
           end
        1: if (!(rw_t || rw_f)) begin phase = 2; dly = int'($urandom_range(0, 4)); end
        default: if (dly == 0) begin
                   ack_in = 1'b0; phase = 0; dly = int'($urandom_range(0, 4));
                 end else dly--;
      endcase

      fetch_req = ($urandom_range(0, 9) < 7);
      ls_req    = ($urandom_range(0, 9) < 7);
      ls_we     = 1'($urandom_range(0, 1));
      pf = fetch_req; pl = ls_req; pw = ls_we;
    end
    chk("r_enough_txns", 32'(txns > 100), 1);

    // ---- handshake timeout and sticky fault ----
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1;
    @(negedge clk);
    chk("d_tok", 32'({rw_t, rw_f}), 32'h2);
    ls_req = 1'b0;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < TMO; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      chk("d_pre_err", 32'(err), 0);
      chk("d_pre_tok", 32'({rw_t, rw_f}), 32'h2);
      @(negedge clk);
      if (done) dones++;
      chk("d_err", 32'(err), 1);
      chk("d_null", 32'({rw_t, rw_f}), 0);
      chk("d_gnt_off", 32'({fetch_gnt, ls_gnt}), 0);
      fetch_req = 1'b1; ls_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
        ack_in = (i % 6) < 3;
        @(negedge clk);
        if (done) dones++;
      end
      chk("d_ignored_gnt", 32'({fetch_gnt, ls_gnt, rw_t, rw_f}), 0);
      chk("d_err_sticky", 32'(err), 1);
      chk("d_no_done", 32'(dones), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
